// File: rtl/prescaler_arbiter.sv
// Round-robin arbiter sharing one prescaler_8bit between NUM_REQ timed-interval requesters.
// Optional watchdog on stalled prescalers is enabled with `define PRESC_ARB_TIMEOUT_EN.
module prescaler_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PER_W     = 4,
    parameter int TMO_TICKS = 512
) (
    input  logic                     clk50m,
    input  logic                     rst,
    input  logic                     en_tick,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*8-1:0]     req_preval,
    input  logic [NUM_REQ*PER_W-1:0] req_periods,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       abort,
    output logic                     busy,
    output logic [7:0]               presc_preval,
    output logic                     presc_clr,
    output logic                     presc_en,
    input  logic                     presc_cnt_zero,
    output logic                     tmo_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [IDX_W-1:0] ptr_r, win_r, arb_idx_s, win_next_s;
    logic             arb_hit_s, abort_hit_s, tmo_hit_s;
    logic [PER_W-1:0] target_r, per_cnt_r, periods_sel_s;
    logic [7:0]       preval_sel_s;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Pick the first requester after the pointer, with wrap, and select its settings
    always_comb begin
        int cand;
        arb_hit_s = 1'b0;
        arb_idx_s = ptr_r;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr_r) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!arb_hit_s && req[cand]) begin
                arb_hit_s = 1'b1;
                arb_idx_s = IDX_W'(cand);
            end else begin
                arb_hit_s = arb_hit_s;
            end
        end
        preval_sel_s  = req_preval[int'(arb_idx_s)*8 +: 8];
        periods_sel_s = req_periods[int'(arb_idx_s)*PER_W +: PER_W];
        if (state_r == ST_IDLE) begin
            win_next_s = arb_idx_s;
        end else begin
            win_next_s = win_r;
        end
    end

    // Next-state logic; a completing cnt_zero takes priority over abort and timeout
    always_comb begin
        state_s     = state_r;
        abort_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_hit_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!req[win_r]) begin
                    state_s     = ST_IDLE;
                    abort_hit_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (presc_cnt_zero && ((per_cnt_r + {{(PER_W-1){1'b0}}, 1'b1}) == target_r)) begin
                    state_s = ST_DONE;
                end else if (!req[win_r] || tmo_hit_s) begin
                    state_s     = ST_IDLE;
                    abort_hit_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    assign presc_en = (state_r == ST_RUN) & en_tick;

    // State, arbitration bookkeeping and registered outputs
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= IDX_W'(NUM_REQ - 1);
            win_r        <= '0;
            target_r     <= '0;
            per_cnt_r    <= '0;
            presc_preval <= 8'h00;
            gnt          <= '0;
            done         <= '0;
            abort        <= '0;
            busy         <= 1'b0;
            presc_clr    <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && arb_hit_s) begin
                win_r        <= arb_idx_s;
                ptr_r        <= arb_idx_s;
                presc_preval <= preval_sel_s;
                target_r     <= (periods_sel_s == '0) ? {{(PER_W-1){1'b0}}, 1'b1} : periods_sel_s;
            end
            if (state_r == ST_LOAD) begin
                per_cnt_r <= '0;
            end else if ((state_r == ST_RUN) && presc_cnt_zero) begin
                per_cnt_r <= per_cnt_r + {{(PER_W-1){1'b0}}, 1'b1};
            end
            gnt       <= (state_s != ST_IDLE) ? idx_onehot(win_next_s) : '0;
            done      <= (state_s == ST_DONE) ? idx_onehot(win_r) : '0;
            abort     <= abort_hit_s ? idx_onehot(win_r) : '0;
            busy      <= (state_s != ST_IDLE);
            presc_clr <= (state_s == ST_LOAD);
        end
    end

`ifdef PRESC_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TMO_TICKS + 1);
    logic [WD_W-1:0] wdog_r;

    assign tmo_hit_s = (state_r == ST_RUN) && en_tick && !presc_cnt_zero
                       && (wdog_r == WD_W'(TMO_TICKS - 1));

    // Watchdog counts enable ticks between terminal counts; error is sticky until reset
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            wdog_r  <= '0;
            tmo_err <= 1'b0;
        end else begin
            if ((state_r == ST_LOAD) || presc_cnt_zero) begin
                wdog_r <= '0;
            end else if ((state_r == ST_RUN) && en_tick) begin
                wdog_r <= wdog_r + {{(WD_W-1){1'b0}}, 1'b1};
            end
            if (tmo_hit_s && (state_s == ST_IDLE)) begin
                tmo_err <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign tmo_err   = 1'b0;
`endif

endmodule

// File: tb/tb_prescaler_arbiter.sv
// Directed bench for prescaler_arbiter with a behavioural prescaler_8bit model.
module tb_prescaler_arbiter;

    logic        clk50m = 1'b0;
    logic        rst = 1'b1;
    logic        en_tick = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_preval = 32'h0;
    logic [15:0] req_periods = 16'h0;
    logic [3:0]  gnt, done, abort;
    logic        busy, presc_clr, presc_en, presc_cnt_zero, tmo_err;
    logic [7:0]  presc_preval;

    logic [7:0]  pcnt;
    logic        pzero;
    logic        block_zero = 1'b0;
    logic        acc_clr = 1'b1;
    int          ticks;
    int          done_total;
    logic [3:0]  done_acc;
    int          n_checks = 0;
    int          n_fail = 0;

    prescaler_arbiter #(.NUM_REQ(4), .PER_W(4), .TMO_TICKS(512)) dut (
        .clk50m(clk50m), .rst(rst), .en_tick(en_tick), .req(req),
        .req_preval(req_preval), .req_periods(req_periods),
        .gnt(gnt), .done(done), .abort(abort), .busy(busy),
        .presc_preval(presc_preval), .presc_clr(presc_clr), .presc_en(presc_en),
        .presc_cnt_zero(presc_cnt_zero), .tmo_err(tmo_err)
    );

    always #10 clk50m = ~clk50m;

    initial begin
        forever begin
            repeat (3) @(negedge clk50m);
            en_tick = 1'b1;
            @(negedge clk50m);
            en_tick = 1'b0;
        end
    end

    // Prescaler model: load on clr, count down on en, pulse and reload at zero
    always @(posedge clk50m or posedge rst) begin
        if (rst) begin
            pcnt  <= 8'h00;
            pzero <= 1'b0;
        end else begin
            pzero <= 1'b0;
            if (presc_clr) begin
                pcnt <= presc_preval;
            end else if (presc_en) begin
                if (pcnt == 8'h00) begin
                    pcnt  <= presc_preval;
                    pzero <= 1'b1;
                end else begin
                    pcnt <= pcnt - 8'd1;
                end
            end
        end
    end
    assign presc_cnt_zero = pzero & ~block_zero;

    // Count gated enable ticks per grant and accumulate done pulses
    always @(posedge clk50m) begin
        if (presc_clr) ticks <= 0;
        else if (presc_en) ticks <= ticks + 1;
        if (acc_clr) begin
            done_acc   <= 4'b0000;
            done_total <= 0;
        end else begin
            done_acc   <= done_acc | done;
            done_total <= done_total + ((done != 4'b0000) ? 1 : 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        acc_clr = 1'b1;
        repeat (2) @(negedge clk50m);
        rst = 1'b0;
        acc_clr = 1'b0;
        @(negedge clk50m);
    endtask

    // sel: 0 done, 1 gnt, 2 abort, 3 ticks>=target
    task automatic wait_for(input int sel, input int target, input int maxc, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge clk50m);
            case (sel)
                0: hit = (done != 4'b0000);
                1: hit = (gnt != 4'b0000);
                2: hit = (abort != 4'b0000);
                default: hit = (ticks >= target);
            endcase
        end
        if (!hit) check_eq(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        do_reset();
        check_eq("rst_gnt", gnt, 4'b0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_outs", {done, abort, presc_clr, presc_en, tmo_err}, 11'h0);
        check_eq("rst_preval", presc_preval, 8'h00);

        // single interval: P=3, two periods -> 8 ticks
        req_preval[7:0] = 8'h03; req_periods[3:0] = 4'd2; req = 4'b0001;
        #1 check_eq("t1_gnt_pre", gnt, 4'b0000);
        @(negedge clk50m);
        check_eq("t1_gnt", gnt, 4'b0001);
        check_eq("t1_clr", presc_clr, 1'b1);
        check_eq("t1_preval", presc_preval, 8'h03);
        check_eq("t1_busy", busy, 1'b1);
        @(negedge clk50m);
        check_eq("t1_clr_off", presc_clr, 1'b0);
        wait_for(0, 0, 200, "t1_done_timeout");
        check_eq("t1_done", done, 4'b0001);
        check_eq("t1_ticks", ticks, 8);
        check_eq("t1_gnt_done", gnt, 4'b0001);
        req = 4'b0000;
        @(negedge clk50m);
        check_eq("t1_busy_off", busy, 1'b0);
        check_eq("t1_gnt_off", {gnt, done}, 8'h00);

        // round robin over all four
        do_reset();
        req_preval = 32'h0; req_periods = 16'h1111; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_for(1, 0, 50, "t2_gnt_timeout");
            check_eq($sformatf("t2_gnt%0d", g), gnt, 4'b0001 << (g % 4));
            wait_for(0, 0, 50, "t2_done_timeout");
            check_eq($sformatf("t2_done%0d", g), done, 4'b0001 << (g % 4));
            if (g == 4) req = 4'b0000;
            @(negedge clk50m);
            check_eq($sformatf("t2_gap%0d", g), {busy, gnt}, 5'h0);
        end
        check_eq("t2_done_total", done_total, 5);

        // zero periods treated as one, P=FF
        do_reset();
        req_preval[7:0] = 8'hFF; req_periods[3:0] = 4'd0; req = 4'b0001;
        wait_for(0, 0, 1500, "t3_done_timeout");
        check_eq("t3_done", done, 4'b0001);
        check_eq("t3_ticks", ticks, 256);
        req = 4'b0000;

        // abort of requester 0 with requester 1 pending
        do_reset();
        req_preval = 32'h0000_020A; req_periods = 16'h0011; req = 4'b0011;
        wait_for(1, 0, 20, "t4_gnt_timeout");
        check_eq("t4_gnt0", gnt, 4'b0001);
        wait_for(3, 3, 100, "t4_tick_timeout");
        req = 4'b0010;
        @(negedge clk50m);
        check_eq("t4_abort", abort, 4'b0001);
        check_eq("t4_abort_outs", {gnt, done, 3'b000, busy}, 12'h0);
        @(negedge clk50m);
        check_eq("t4_gnt1", gnt, 4'b0010);
        check_eq("t4_abort_off", abort, 4'b0000);
        wait_for(0, 0, 100, "t4_done_timeout");
        check_eq("t4_done1", done, 4'b0010);
        check_eq("t4_ticks1", ticks, 3);
        req = 4'b0000;
        @(negedge clk50m);
        check_eq("t4_done_acc", done_acc, 4'b0010);

        // asynchronous reset during RUN of requester 2
        do_reset();
        req_preval = 32'h0005_0000; req_periods = 16'h0300; req = 4'b0100;
        wait_for(3, 2, 100, "t5_tick_timeout");
        #3 rst = 1'b1;
        #1 check_eq("t5_rst_gnt", {gnt, done, abort}, 12'h0);
        check_eq("t5_rst_misc", {busy, presc_clr, presc_en, presc_preval}, 11'h0);
        @(negedge clk50m);
        rst = 1'b0;
        @(negedge clk50m);
        check_eq("t5_regnt", gnt, 4'b0100);
        check_eq("t5_no_pulse", {done, abort}, 8'h00);
        rst = 1'b1;
        req = 4'b0101;
        @(negedge clk50m);
        rst = 1'b0;
        @(negedge clk50m);
        check_eq("t5_ptr_reset", gnt, 4'b0001);
        req = 4'b0000;

`ifdef PRESC_ARB_TIMEOUT_EN
        // watchdog with a stalled prescaler
        do_reset();
        block_zero = 1'b1;
        req_preval = 32'h0; req_periods = 16'h0001; req = 4'b0001;
        wait_for(2, 0, 2400, "t6_abort_timeout");
        check_eq("t6_abort", abort, 4'b0001);
        check_eq("t6_ticks", ticks, 512);
        check_eq("t6_tmo", tmo_err, 1'b1);
        check_eq("t6_no_done", done_acc, 4'b0000);
        req = 4'b0000;
        repeat (5) @(negedge clk50m);
        check_eq("t6_tmo_sticky", tmo_err, 1'b1);
        block_zero = 1'b0;
        do_reset();
        check_eq("t6_tmo_clr", tmo_err, 1'b0);
`else
        check_eq("tmo_tied", tmo_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prescaler_arbiter.md
Name: prescaler_arbiter

Overview:
- Shares one prescaler_8bit instance between NUM_REQ requesters. Each requester asks for a timed interval of N prescaler periods at its own reload value.
- Grants are round-robin. For each grant the block loads the reload value, clears the prescaler and gates the 1 kHz enable tick into it. It counts cnt_zero events and then signals done to the granted requester.
- Sits between the prescale_50m_1k tick source and prescaler_8bit in the DSM DAC toplevel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PER_W, 4, width of the per-requester period count.
- TMO_TICKS, 512, watchdog limit in en_tick pulses (used only with the optional feature).

Ports:
- clk50m  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- en_tick  in  1  1-clk enable pulse from prescale_50m_1k
- req  in  NUM_REQ  level request per requester; held until done or abort
- req_preval  in  NUM_REQ*8  reload value, requester i at bits [8i+7:8i]
- req_periods  in  NUM_REQ*PER_W  number of cnt_zero events to wait; 0 is treated as 1
- gnt  out  NUM_REQ  one-hot grant, high from LOAD through DONE
- done  out  NUM_REQ  one-clk one-hot pulse when the interval completes
- abort  out  NUM_REQ  one-clk one-hot pulse when req drops during service
- busy  out  1  high in any state other than IDLE
- presc_preval  out  8  reload value driven to the prescaler
- presc_clr  out  1  one-clk synchronous clear/reload to the prescaler
- presc_en  out  1  gated enable to the prescaler
- presc_cnt_zero  in  1  prescaler terminal-count pulse
- tmo_err  out  1  sticky watchdog error (optional feature only)

Behaviour:
- Prescaler contract: after presc_clr the count equals presc_preval. Each presc_en decrements the count. presc_cnt_zero pulses for one clk when the count reaches 0, then the count reloads. Period is P+1 en ticks.
- Reset values:
  - gnt, done, abort, presc_clr, presc_en = 0; busy = 0.
  - presc_preval = 8'h00; tmo_err = 0.
  - Round-robin pointer = requester NUM_REQ-1, so requester 0 has first priority.
  - State = IDLE.
- IDLE:
  - If any req bit is set, latch the winner: the first set bit searching from pointer+1 upward with wrap.
  - Latch its preval and periods (0 becomes 1), update the pointer, go to LOAD.
- LOAD (1 clk):
  - gnt[winner]=1, presc_clr=1, presc_preval = latched value; period counter cleared. Go to RUN.
- RUN:
  - presc_en = en_tick combinationally; gnt held.
  - Each presc_cnt_zero increments the period counter. When the counter reaches the latched periods, go to DONE.
  - presc_preval stays stable; changes on req_preval during RUN are ignored.
- DONE (1 clk):
  - done[winner]=1, gnt still 1, presc_en=0. Go to IDLE.
  - Next arbitration happens in the following IDLE cycle, so there is a minimum 1 idle clk between grants.
- Abort: if req[winner] falls in LOAD or RUN:
  - abort[winner] pulses in the next clk and gnt drops with it.
  - Return to IDLE; no done is issued; the pointer keeps the aborted winner.
- Simultaneous events:
  - cnt_zero that completes the count in the same clk as req falling: done wins, abort is not issued.
  - en_tick outside RUN is discarded.
- Latency: req rise in IDLE leads to gnt 1 clk later. The first presc_en can occur 2 clk after req rise.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); no done or abort pulse is issued.
- Width rule: the period counter is PER_W bits and cannot overflow, because the target is at most 2^PER_W-1.

Optional Feature:
- Macro: PRESC_ARB_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts en_tick in RUN and clears on each presc_cnt_zero and on LOAD.
  - When it reaches TMO_TICKS, tmo_err is set (sticky until rst), abort[winner] pulses, and the FSM returns to IDLE.
- Without the macro: no watchdog logic exists; tmo_err is tied to 0 and RUN waits indefinitely.

Test Plan:
- Reset, then req=4'b0001, preval0=8'h03, periods0=2 -> gnt0 1 clk after req; presc_clr for 1 clk; done0 after exactly 8 en_ticks; busy falls the clk after done.
- req=4'b1111, all preval=0, periods=1 -> grants in order 0,1,2,3,0 with exactly one done per grant, and at least 1 idle clk between gnt intervals.
- periods0=0, preval0=8'hFF -> treated as 1; done0 after 256 en_ticks.
- req0 dropped after 3 en_ticks of RUN (preval 8'h0A) -> abort0 pulse, no done0; a pending req1 is granted next.
- rst asserted during RUN of requester 2 -> all outputs 0 immediately; after release, req=4'b0100 still set -> requester 2 granted again first-come; pointer reset so requester 0 wins if also requesting.
- PRESC_ARB_TIMEOUT_EN defined, presc_cnt_zero held 0 -> after 512 en_ticks tmo_err=1 and abort pulses; tmo_err stays 1 until rst.
